// File: rtl/botones_entrada_if.sv
// Board-side bundle for the button/tilt conditioner: raw pin inputs in,
// clean command pulses and levels out towards the pet state machine.
interface botones_entrada_if;
    logic btn_sleep_raw;
    logic btn_awake_raw;
    logic btn_feed_raw;
    logic btn_play_raw;
    logic giro_raw;
    logic botonSleep;
    logic botonAwake;
    logic botonFeed;
    logic botonPlay;
    logic giro;
    logic reset_req;

    modport master (
        output btn_sleep_raw, btn_awake_raw, btn_feed_raw, btn_play_raw, giro_raw,
        input  botonSleep, botonAwake, botonFeed, botonPlay, giro, reset_req
    );

    modport slave (
        input  btn_sleep_raw, btn_awake_raw, btn_feed_raw, btn_play_raw, giro_raw,
        output botonSleep, botonAwake, botonFeed, botonPlay, giro, reset_req
    );
endinterface

// File: rtl/botones_entrada.sv
// Button/tilt front-end: synchronise, debounce and arbitrate raw board inputs
// into one-cycle command pulses, a stable tilt level and a long-press reset request.
module botones_entrada #(
    parameter int TICK_DIV       = 50000,
    parameter int DEB_MS         = 20,
    parameter int LONG_MS        = 2000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    botones_entrada_if.slave bus
);
    localparam int NCH      = 5;
    localparam int NBTN     = 4;
    localparam int CH_SLEEP = 0;
    localparam int CH_AWAKE = 1;
    localparam int CH_FEED  = 2;
    localparam int CH_PLAY  = 3;
    localparam int CH_GIRO  = 4;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DEB_MS   > 1) ? $clog2(DEB_MS)   : 1;
    localparam int LW = (LONG_MS  > 1) ? $clog2(LONG_MS)  : 1;

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   DEB_LAST  = CW'(DEB_MS - 1);
    localparam logic [LW-1:0]   LONG_LAST = LW'(LONG_MS - 1);
    localparam logic [NBTN-1:0] BTN_POL   = {NBTN{BTN_ACTIVE_LOW}};
    localparam logic [NCH-1:0]  SYNC_INIT = {1'b0, BTN_POL};
    localparam logic [NBTN-1:0] LONG_CLR  = 4'b0011;

    typedef enum logic [1:0] {RELEASED, CHK_PRESS, PRESSED, CHK_REL} chan_state_t;

    logic [NCH-1:0]  raw_in;
    logic [NCH-1:0]  sync1_reg;
    logic [NCH-1:0]  sync2_reg;
    logic [NCH-1:0]  chan_in;
    logic [NCH-1:0]  stable;
    logic [NBTN-1:0] press_evt;
    logic [TW-1:0]   tick_cnt_reg;
    logic            tick;

    assign raw_in = {bus.giro_raw, bus.btn_play_raw, bus.btn_feed_raw,
                     bus.btn_awake_raw, bus.btn_sleep_raw};

    // Flops preload the idle level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= SYNC_INIT;
            sync2_reg <= SYNC_INIT;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign chan_in = sync2_reg ^ SYNC_INIT;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      tick_cnt_reg <= '0;
        else if (tick) tick_cnt_reg <= '0;
        else           tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            chan_state_t   state_reg, state_next;
            logic [CW-1:0] cnt_reg, cnt_next;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= RELEASED;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                unique case (state_reg)
                    RELEASED: begin
                        if (chan_in[gi]) begin
                            state_next = CHK_PRESS;
                            cnt_next   = '0;
                        end
                    end
                    CHK_PRESS: begin
                        if (!chan_in[gi]) begin
                            state_next = RELEASED;
                            cnt_next   = '0;
                        end else if (tick) begin
                            if (cnt_reg == DEB_LAST) begin
                                state_next = PRESSED;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                    end
                    PRESSED: begin
                        if (!chan_in[gi]) begin
                            state_next = CHK_REL;
                            cnt_next   = '0;
                        end
                    end
                    CHK_REL: begin
                        if (chan_in[gi]) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                        end else if (tick) begin
                            if (cnt_reg == DEB_LAST) begin
                                state_next = RELEASED;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                    end
                endcase
            end

            assign stable[gi] = (state_reg == PRESSED) || (state_reg == CHK_REL);

            // Only the not-yet-stable -> PRESSED transition is a press; release is silent.
            if (gi < NBTN) begin : g_evt
                assign press_evt[gi] = !stable[gi] && (state_next == PRESSED);
            end
        end
    endgenerate

    logic          both_held;
    logic          long_fire;
    logic [LW-1:0] long_cnt_reg;
    logic          long_done_reg;

    assign both_held = stable[CH_SLEEP] && stable[CH_AWAKE];
    assign long_fire = both_held && tick && !long_done_reg && (long_cnt_reg == LONG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
        end else if (!both_held) begin
            long_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
        end else if (tick && !long_done_reg) begin
            if (long_cnt_reg == LONG_LAST) long_done_reg <= 1'b1;
            else                           long_cnt_reg  <= long_cnt_reg + 1'b1;
        end
    end

    logic [NBTN-1:0] pend_reg, pend_next;
    logic [NBTN-1:0] eff;
    logic [NBTN-1:0] grant;
    logic [NBTN-1:0] cmd_reg;
    logic            giro_reg;
    logic            reset_req_reg;

    // A fresh event on a bit being served keeps it pending, but only if it was already queued.
    always_comb begin
        eff   = (pend_reg | press_evt) & ~({NBTN{long_fire}} & LONG_CLR);
        grant = '0;
        if (eff[CH_AWAKE])      grant[CH_AWAKE] = 1'b1;
        else if (eff[CH_FEED])  grant[CH_FEED]  = 1'b1;
        else if (eff[CH_SLEEP]) grant[CH_SLEEP] = 1'b1;
        else if (eff[CH_PLAY])  grant[CH_PLAY]  = 1'b1;
        pend_next = (eff & ~grant) | (press_evt & pend_reg & grant);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg      <= '0;
            cmd_reg       <= '0;
            giro_reg      <= 1'b0;
            reset_req_reg <= 1'b0;
        end else begin
            pend_reg      <= pend_next;
            cmd_reg       <= grant;
            giro_reg      <= stable[CH_GIRO];
            reset_req_reg <= long_fire;
        end
    end

    assign bus.botonSleep = cmd_reg[CH_SLEEP];
    assign bus.botonAwake = cmd_reg[CH_AWAKE];
    assign bus.botonFeed  = cmd_reg[CH_FEED];
    assign bus.botonPlay  = cmd_reg[CH_PLAY];
    assign bus.giro       = giro_reg;
    assign bus.reset_req  = reset_req_reg;
endmodule
